// File: rtl/wb_arbiter_if.sv
// Bundle of functional-unit result requests and the registered regfile writeback port.
// The arbiter takes the slave view; whatever drives the FUs and consumes the writes takes the master view.
interface wb_arbiter_if #(
    parameter int NUM_FU = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU*REG_W-1:0]  fu_rd;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]        fu_ready;
    logic                     wb_stall;
    logic                     flush;
    logic                     wb_en;
    logic [REG_W-1:0]         wb_rd;
    logic [DATA_W-1:0]        wb_data;
    logic [2:0]               wb_fu;

    modport slave (
        input  fu_valid, fu_rd, fu_data, wb_stall, flush,
        output fu_ready, wb_en, wb_rd, wb_data, wb_fu
    );

    modport master (
        output fu_valid, fu_rd, fu_data, wb_stall, flush,
        input  fu_ready, wb_en, wb_rd, wb_data, wb_fu
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding entry per functional unit, round-robin grant of one
// entry per cycle onto a registered regfile write port, with stall backpressure and flush.
module wb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input logic        CLK,
    input logic        nrst,
    wb_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] buf_valid;
    logic [REG_W-1:0]  buf_rd   [NUM_FU];
    logic [DATA_W-1:0] buf_data [NUM_FU];
    logic [PTR_W-1:0]  rr_ptr;

    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] accept;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  rr_next;
    logic              grant_any;
    logic [PTR_W:0]    cand;

    // Round-robin search from rr_ptr upward, wrapping at NUM_FU; first valid entry wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!bus.wb_stall && !bus.flush) begin
            for (int k = 0; k < NUM_FU; k++) begin
                cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (cand >= (PTR_W+1)'(NUM_FU))
                    cand = cand - (PTR_W+1)'(NUM_FU);
                if (!grant_any && buf_valid[cand[PTR_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = cand[PTR_W-1:0];
                end
            end
        end
    end

    assign grant   = grant_any ? (NUM_FU'(1) << grant_idx) : '0;
    assign rr_next = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + PTR_W'(1);

    // An entry being drained this cycle can be refilled in the same cycle.
    assign bus.fu_ready = (~buf_valid | grant) & {NUM_FU{~bus.flush}};
    assign accept       = bus.fu_valid & bus.fu_ready;

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            buf_valid <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                buf_rd[i]   <= '0;
                buf_data[i] <= '0;
            end
        end else if (bus.flush) begin
            buf_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                // Writes to r0 are acknowledged but never buffered.
                if (accept[i] && (bus.fu_rd[i*REG_W +: REG_W] != '0)) begin
                    buf_valid[i] <= 1'b1;
                    buf_rd[i]    <= bus.fu_rd[i*REG_W +: REG_W];
                    buf_data[i]  <= bus.fu_data[i*DATA_W +: DATA_W];
                end else if (accept[i] || grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            bus.wb_en   <= 1'b0;
            bus.wb_rd   <= '0;
            bus.wb_data <= '0;
            bus.wb_fu   <= '0;
            rr_ptr      <= '0;
        end else if (grant_any) begin
            bus.wb_en   <= 1'b1;
            bus.wb_rd   <= buf_rd[grant_idx];
            bus.wb_data <= buf_data[grant_idx];
            bus.wb_fu   <= 3'(grant_idx);
            rr_ptr      <= rr_next;
        end else begin
            bus.wb_en   <= 1'b0;
        end
    end

    a_grant_onehot: assert property (@(posedge CLK) disable iff (!nrst) $onehot0(grant));

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_FU, default 4, giving the number of functional-unit result requesters (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the writeback data width.
REQ-003 The block SHALL have parameter REG_W, default 5, giving the destination register index width.
REQ-004 The block SHALL have port CLK  in  1  clock; all state updates on the rising edge.
REQ-005 The block SHALL have port nrst  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port fu_valid  in  NUM_FU  per-FU result valid.
REQ-007 The block SHALL have port fu_rd  in  NUM_FU*REG_W  per-FU destination register, FU i in slice [i*REG_W +: REG_W].
REQ-008 The block SHALL have port fu_data  in  NUM_FU*DATA_W  per-FU result data, FU i in slice [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have port fu_ready  out  NUM_FU  per-FU accept; a transfer occurs when fu_valid[i] and fu_ready[i] are both high at a clock edge.
REQ-010 The block SHALL have port wb_stall  in  1  writeback stall; blocks new grants.
REQ-011 The block SHALL have port flush  in  1  discards all buffered results.
REQ-012 The block SHALL have port wb_en  out  1  registered regfile write enable.
REQ-013 The block SHALL have port wb_rd  out  REG_W  registered write register index.
REQ-014 The block SHALL have port wb_data  out  DATA_W  registered write data.
REQ-015 The block SHALL have port wb_fu  out  3  registered index of the FU that sourced the current write.

Function
REQ-016 Buffering: one holding entry per FU (valid bit, rd, data).
REQ-017 fu_ready[i] SHALL be the combinational term (!buf_valid[i] || grant[i]) && !flush.
REQ-018 Accepting a transfer with fu_rd[i]==0 SHALL discard it; buf_valid[i] is not set, and the transfer is still acknowledged.
REQ-019 Arbitration SHALL be combinational each cycle over buf_valid, gated by !wb_stall && !flush, and SHALL grant at most one FU.
REQ-020 Priority SHALL be round-robin: search starts at rr_ptr and ascends modulo NUM_FU; the first valid entry wins.
REQ-021 On a grant to FU g, rr_ptr SHALL become (g+1) mod NUM_FU at the next edge; with no grant, rr_ptr holds.
REQ-022 On a grant, the next edge SHALL load wb_en=1, wb_rd, wb_data and wb_fu from entry g, and SHALL clear buf_valid[g] unless it is refilled in the same cycle.
REQ-023 Simultaneous grant and new accept on the same FU SHALL replace the entry with the new result, leaving buf_valid[g]=1.
REQ-024 With no grant, wb_en SHALL be 0 at the next edge, and wb_rd, wb_data and wb_fu SHALL hold their values.
REQ-025 Latency: a result accepted at edge t SHALL produce wb_en at edge t+1 at the earliest, when it is uncontended and wb_stall=0.
REQ-026 wb_stall=1 SHALL leave all buffers intact; FUs with full buffers see fu_ready=0 (backpressure).
REQ-027 flush=1 SHALL clear all buf_valid at the next edge, force wb_en=0 at the next edge, accept nothing and grant nothing; rr_ptr holds.
REQ-028 flush takes precedence over wb_stall and over new transfers.
REQ-029 Throughput: one write per cycle whenever any entry is valid and the stage is not stalled or flushed.

Reset
REQ-030 While nrst=0, asynchronously: buf_valid=0, rr_ptr=0, wb_en=0, wb_rd=0, wb_data=0, wb_fu=0; fu_ready follows REQ-017 from the cleared state.
REQ-031 Reset mid-operation SHALL drop all buffered results without emitting any write.

Verification
REQ-032 Single FU1 result rd=3, data=0xDEADBEEF at edge t -> wb_en=1, wb_rd=3, wb_data=0xDEADBEEF, wb_fu=1 at edge t+1; wb_en=0 at t+2.
REQ-033 All 4 FUs valid together, rr_ptr=0, rd=1..4 -> writes from FU0,1,2,3 on 4 consecutive cycles; rr_ptr returns to 0.
REQ-034 FU2 full, wb_stall=1 for 3 cycles -> fu_ready[2]=0 and wb_en=0 for 3 cycles; FU2 data written on the first edge after stall release.
REQ-035 FU0 entry granted while FU0 presents new rd=7 in the same cycle -> old entry written; new entry written next grant; no loss and no duplicate.
REQ-036 Two entries buffered, then flush=1 for one cycle -> wb_en=0 and all buf_valid=0; no later write of the old data.
REQ-037 Transfer with rd=0 -> accepted (fu_ready=1); wb_en never asserts for it. Separately, nrst pulsed with 3 entries buffered -> all outputs 0 and no writes after release.
